// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC playback sequencer.
// Holds the sequencer state encoding, default sizes and named DAC codes.
package dac_seq_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int CODE_W_DEF = 4;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  localparam logic [CODE_W_DEF-1:0] CODE_ZERO     = '0;
  localparam logic [CODE_W_DEF-1:0] CODE_MIDSCALE = {1'b1, {(CODE_W_DEF-1){1'b0}}};

endpackage

// File: rtl/dac_seq_rate_div.sv
// Reloadable down-counter that sets the sample period of the sequencer.
// tick marks the last enabled cycle of a period (count at zero).
module dac_seq_rate_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/dac_seq_ctrl.sv
// Playback sequencer for the 4-bit R-2R DAC: buffers sample codes written in
// IDLE, then replays them one-shot or looping at a programmable rate.
module dac_seq_ctrl
  import dac_seq_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CODE_W-1:0]        wr_data,
  input  logic                     clr_ptr,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [$clog2(DEPTH)-1:0] len,
  input  logic [DIV_W-1:0]         div,
  output logic [CODE_W-1:0]        dac_code,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     len_s_q, len_s_d;
  logic [DIV_W-1:0]  div_s_q, div_s_d;
  logic              loop_s_q, loop_s_d;
  logic              done_q, done_d;
  logic [CODE_W-1:0] dac_q, dac_d;
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];

  logic              play;
  logic              last_smp;
  logic              tick;
  logic              cnt_load;
  logic [DIV_W-1:0]  cnt_load_val;

  assign play     = (state_q == ST_PLAY);
  assign wr_ready = ena && !play;
  // rd_ptr already points one past the sample on the pins; wraps cleanly when len = DEPTH-1.
  assign last_smp = ((rd_ptr_q - AW'(1)) == len_s_q);

  dac_seq_rate_div #(
    .DIV_W (DIV_W)
  ) u_rate_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ena && play),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (tick)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    len_s_d      = len_s_q;
    div_s_d      = div_s_q;
    loop_s_d     = loop_s_q;
    dac_d        = dac_q;
    mem_d        = mem_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = div_s_q;

    if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          if (wr_valid && wr_ready) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
          end
          if (clr_ptr) begin
            wr_ptr_d = '0;
          end
          // stop asserted alongside start keeps the sequencer idle
          if (start && !stop) begin
            state_d      = ST_PLAY;
            len_s_d      = len;
            div_s_d      = div;
            loop_s_d     = loop_en;
            dac_d        = mem_d[0];
            rd_ptr_d     = AW'(1);
            cnt_load     = 1'b1;
            cnt_load_val = div;
          end
        end
        ST_PLAY: begin
          if (stop) begin
            state_d      = ST_IDLE;
            dac_d        = CODE_W'(CODE_ZERO);
            cnt_load     = 1'b1;
            cnt_load_val = '0;
          end else if (tick) begin
            if (!last_smp) begin
              dac_d    = mem_q[rd_ptr_q];
              rd_ptr_d = rd_ptr_q + AW'(1);
              cnt_load = 1'b1;
            end else if (loop_s_q) begin
              dac_d    = mem_q[0];
              rd_ptr_d = AW'(1);
              cnt_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_s_q  <= '0;
      div_s_q  <= '0;
      loop_s_q <= 1'b0;
      done_q   <= 1'b0;
      dac_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_s_q  <= len_s_d;
      div_s_q  <= div_s_d;
      loop_s_q <= loop_s_d;
      done_q   <= done_d;
      dac_q    <= dac_d;
      mem_q    <= mem_d;
    end
  end

  assign dac_code = dac_q;
  assign busy     = play;
  assign done     = done_q;

endmodule
